// File: rtl/nrs_pkg.sv
// rtl/nrs_pkg.sv - shared types, constants and position helpers for the NRS sequencer
package nrs_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DONE
    } nrs_state_e;

    localparam int NRS_SYM0     = 5;
    localparam int NRS_SYM1     = 6;
    localparam int SYM_PER_SLOT = 7;
    localparam int N_SC         = 12;
    localparam int MAX_CELL_ID  = 503;

    function automatic logic [3:0] nrs_sym(input logic slot, input logic sym_sel);
        nrs_sym = 4'(slot ? SYM_PER_SLOT : 0) + 4'(sym_sel ? NRS_SYM1 : NRS_SYM0);
    endfunction

    // v is 0 or 3, so (v + v_shift) never exceeds 8 and one subtract suffices.
    function automatic logic [3:0] nrs_k(input logic sym_sel, input logic port,
                                         input logic m, input logic [2:0] v_shift);
        logic [3:0] sum;
        sum = ((sym_sel ^ port) ? 4'd3 : 4'd0) + {1'b0, v_shift};
        if (sum >= 4'd6) sum = sum - 4'd6;
        nrs_k = (m ? 4'd6 : 4'd0) + sum;
    endfunction

endpackage

// File: rtl/nrs_vshift_mod6.sv
// rtl/nrs_vshift_mod6.sv - combinational 9-bit cell ID mod 6, shared with the TX generator
module nrs_vshift_mod6 (
    input  logic [8:0] cell_id_i,
    output logic [2:0] v_shift_o
);

    logic [2:0] odd_sum;
    logic [2:0] even_sum;
    logic [4:0] r;

    // 2^odd == 2 and 2^even (>0) == 4 modulo 6, so fold bits by weight class.
    always_comb begin
        odd_sum  = 3'(cell_id_i[1]) + 3'(cell_id_i[3]) + 3'(cell_id_i[5]) + 3'(cell_id_i[7]);
        even_sum = 3'(cell_id_i[2]) + 3'(cell_id_i[4]) + 3'(cell_id_i[6]) + 3'(cell_id_i[8]);
        r        = 5'(cell_id_i[0]) + {1'b0, odd_sum, 1'b0} + {even_sum, 2'b00};
        for (int i = 0; i < 4; i++) begin
            if (r >= 5'd6) r = r - 5'd6;
        end
        v_shift_o = r[2:0];
    end

endmodule

// File: rtl/nrs_re_sequencer.sv
// rtl/nrs_re_sequencer.sv - streams NRS resource-element positions for N_SF subframes per start
module nrs_re_sequencer
    import nrs_pkg::*;
#(
    parameter int MAX_PORTS = 2,
    parameter int N_SF      = 1,
    parameter int SF_W      = (N_SF > 1) ? $clog2(N_SF) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [8:0]      N_cell_ID,
    input  logic            two_ports,
    input  logic            abort,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [3:0]      index_demap,
    output logic [3:0]      sym_idx,
    output logic            port_idx,
    output logic [SF_W-1:0] sf_idx,
    output logic [7:0]      re_addr,
    output logic [2:0]      v_shift,
    output logic            busy,
    output logic            done
);

    nrs_state_e      state_q;
    logic [8:0]      cell_id_q;
    logic            two_ports_q;
    logic [SF_W-1:0] sf_q, sf_d;
    logic            slot_q, slot_d;
    logic            sym_sel_q, sym_sel_d;
    logic            port_q, port_d;
    logic            m_q, m_d;
    logic            valid_q, busy_q, done_q;
    logic [3:0]      k_q, k_d;
    logic [3:0]      sym_q, sym_d;
    logic [7:0]      re_q, re_d;
    logic [2:0]      vs_q, vs_comb;
    logic            last;
    logic            pay_slot, pay_ss, pay_port, pay_m;
    logic [2:0]      pay_vs;

    nrs_vshift_mod6 u_mod6 (
        .cell_id_i (cell_id_q),
        .v_shift_o (vs_comb)
    );

    // Counter nest, inner to outer: m, port, symbol-in-slot, slot, subframe.
    always_comb begin
        m_d       = ~m_q;
        port_d    = port_q;
        sym_sel_d = sym_sel_q;
        slot_d    = slot_q;
        sf_d      = sf_q;
        if (m_q) begin
            if (two_ports_q && !port_q) begin
                port_d = 1'b1;
            end else begin
                port_d    = 1'b0;
                sym_sel_d = ~sym_sel_q;
                if (sym_sel_q) begin
                    slot_d = ~slot_q;
                    if (slot_q) sf_d = sf_q + 1'b1;
                end
            end
        end
        last = m_q && (port_q == two_ports_q) && sym_sel_q && slot_q
               && (sf_q == SF_W'(N_SF - 1));

        // LOAD presents position zero using the freshly reduced cell ID.
        if (state_q == S_LOAD) begin
            pay_slot = 1'b0;
            pay_ss   = 1'b0;
            pay_port = 1'b0;
            pay_m    = 1'b0;
            pay_vs   = vs_comb;
        end else begin
            pay_slot = slot_d;
            pay_ss   = sym_sel_d;
            pay_port = port_d;
            pay_m    = m_d;
            pay_vs   = vs_q;
        end
        k_d   = nrs_k(pay_ss, pay_port, pay_m, pay_vs);
        sym_d = nrs_sym(pay_slot, pay_ss);
        re_d  = 8'(sym_d) * 8'(N_SC) + 8'(k_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cell_id_q   <= '0;
            two_ports_q <= 1'b0;
            sf_q        <= '0;
            slot_q      <= 1'b0;
            sym_sel_q   <= 1'b0;
            port_q      <= 1'b0;
            m_q         <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            k_q         <= '0;
            sym_q       <= '0;
            re_q        <= '0;
            vs_q        <= '0;
        end else if (abort) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        cell_id_q   <= N_cell_ID;
                        two_ports_q <= (MAX_PORTS == 2) && two_ports;
                        busy_q      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q   <= S_EMIT;
                    vs_q      <= vs_comb;
                    sf_q      <= '0;
                    slot_q    <= 1'b0;
                    sym_sel_q <= 1'b0;
                    port_q    <= 1'b0;
                    m_q       <= 1'b0;
                    valid_q   <= 1'b1;
                    k_q       <= k_d;
                    sym_q     <= sym_d;
                    re_q      <= re_d;
                end
                S_EMIT: begin
                    if (valid_q && out_ready) begin
                        if (last) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            sf_q      <= sf_d;
                            slot_q    <= slot_d;
                            sym_sel_q <= sym_sel_d;
                            port_q    <= port_d;
                            m_q       <= m_d;
                            k_q       <= k_d;
                            sym_q     <= sym_d;
                            re_q      <= re_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid   = valid_q;
    assign index_demap = k_q;
    assign sym_idx     = sym_q;
    assign port_idx    = port_q;
    assign sf_idx      = sf_q;
    assign re_addr     = re_q;
    assign v_shift     = vs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_nrs_re_sequencer.sv
// tb/tb_nrs_re_sequencer.sv - scoreboard bench for nrs_re_sequencer
module tb_nrs_re_sequencer;

    localparam int MAX_PORTS = 2;
    localparam int N_SF      = 4;
    localparam int SF_W      = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [8:0]      N_cell_ID = '0;
    logic            two_ports = 1'b0;
    logic            abort = 1'b0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [3:0]      index_demap;
    logic [3:0]      sym_idx;
    logic            port_idx;
    logic [SF_W-1:0] sf_idx;
    logic [7:0]      re_addr;
    logic [2:0]      v_shift;
    logic            busy;
    logic            done;

    typedef struct {
        int k;
        int sym;
        int port;
        int sf;
        int re;
    } pos_t;

    pos_t exp_q[$];
    int   obs_re[$];
    int   obs_k[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    nrs_re_sequencer #(
        .MAX_PORTS (MAX_PORTS),
        .N_SF      (N_SF),
        .SF_W      (SF_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .N_cell_ID   (N_cell_ID),
        .two_ports   (two_ports),
        .abort       (abort),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .index_demap (index_demap),
        .sym_idx     (sym_idx),
        .port_idx    (port_idx),
        .sf_idx      (sf_idx),
        .re_addr     (re_addr),
        .v_shift     (v_shift),
        .busy        (busy),
        .done        (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        tests_run++;
        if (got !== 32'(exp)) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] payload();
        return 32'({index_demap, sym_idx, port_idx, sf_idx, re_addr});
    endfunction

    task automatic push_run(input int id, input bit tp);
        pos_t e;
        int   vs;
        vs = id % 6;
        for (int sf = 0; sf < N_SF; sf++)
            for (int slot = 0; slot < 2; slot++)
                for (int ss = 0; ss < 2; ss++)
                    for (int p = 0; p < (tp ? 2 : 1); p++)
                        for (int m = 0; m < 2; m++) begin
                            e.sym  = 5 + ss + 7 * slot;
                            e.port = p;
                            e.sf   = sf;
                            e.k    = 6 * m + ((3 * (ss ^ p)) + vs) % 6;
                            e.re   = e.sym * 12 + e.k;
                            exp_q.push_back(e);
                        end
    endtask

    task automatic run(input int id, input bit tp, input int low_pct,
                       input int abort_at, input bit start_in_load);
        int          n;
        int          n_exp;
        bit          stalled;
        bit          finished;
        logic [31:0] held;
        pos_t        e;
        exp_q.delete();
        obs_re.delete();
        obs_k.delete();
        push_run(id, tp);
        n_exp = exp_q.size();
        @(negedge clk);
        start = 1'b1; N_cell_ID = 9'(id); two_ports = tp; out_ready = 1'b0;
        @(negedge clk);
        start = start_in_load;
        check_eq("busy_in_load", busy, 1);
        check_eq("valid_in_load", out_valid, 0);
        n = 0; stalled = 0; finished = 0; held = '0;
        for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == n_exp) begin
                check_eq("done_after_last", done, 1);
                check_eq("busy_at_done", busy, 0);
                check_eq("valid_at_done", out_valid, 0);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_eq("done_one_cycle", done, 0);
                check_eq("start_in_done_ignored", busy, 0);
                finished = 1;
            end else if (done) begin
                check_eq("early_done", n, n_exp);
                finished = 1;
            end else begin
                if (stalled) begin
                    check_eq("stall_valid", out_valid, 1);
                    check_eq("stall_hold", payload(), int'(held));
                end
                if (out_valid) begin
                    if (n == 0) check_eq("v_shift", v_shift, id % 6);
                    if (abort_at == n) begin
                        abort = 1'b1; out_ready = 1'b1;
                        @(negedge clk);
                        abort = 1'b0;
                        check_eq("abort_valid", out_valid, 0);
                        check_eq("abort_busy", busy, 0);
                        check_eq("abort_done", done, 0);
                        @(negedge clk);
                        check_eq("abort_no_done", done, 0);
                        check_eq("abort_stays_idle", out_valid, 0);
                        finished = 1;
                    end else begin
                        out_ready = ($urandom_range(0, 99) >= low_pct);
                        if (out_ready) begin
                            if (exp_q.size() == 0) begin
                                check_eq("extra_transfer", n, n_exp);
                                finished = 1;
                            end else begin
                                e = exp_q.pop_front();
                                check_eq("k", index_demap, e.k);
                                check_eq("sym", sym_idx, e.sym);
                                check_eq("port", port_idx, e.port);
                                check_eq("sf", sf_idx, e.sf);
                                check_eq("re_addr", re_addr, e.re);
                                check_eq("k_range", (index_demap <= 4'd11), 1);
                                obs_re.push_back(int'(re_addr));
                                obs_k.push_back(int'(index_demap));
                                n++;
                                stalled = 0;
                            end
                        end else begin
                            stalled = 1;
                            held    = payload();
                        end
                    end
                end
            end
        end
        if (!finished) check_eq("run_timeout", 0, 1);
        out_ready = 1'b0;
    endtask

    int re_tab[8] = '{60, 66, 75, 81, 144, 150, 159, 165};
    int k_tab[8]  = '{5, 11, 2, 8, 2, 8, 5, 11};

    initial begin
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sym", sym_idx, 0);
        check_eq("rst_re", re_addr, 0);
        check_eq("rst_vshift", v_shift, 0);
        check_eq("rst_k", index_demap, 0);
        check_eq("rst_sf", sf_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(0, 1'b0, 0, -1, 1'b0);
        check_eq("count_p1", obs_re.size(), 8 * 1 * N_SF);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("re_seq%0d", i), (obs_re.size() > i) ? obs_re[i] : -1, re_tab[i]);

        run(503, 1'b1, 0, -1, 1'b0);
        check_eq("count_p2", obs_k.size(), 8 * 2 * N_SF);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("k_seq%0d", i), (obs_k.size() > i) ? obs_k[i] : -1, k_tab[i]);

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("start_with_abort_ignored", busy, 0);

        run(137, 1'b1, 30, -1, 1'b0);
        check_eq("count_backpressure", obs_re.size(), 8 * 2 * N_SF);

        run(200, 1'b1, 0, 9, 1'b0);
        check_eq("count_before_abort", obs_re.size(), 9);
        run(200, 1'b1, 0, -1, 1'b0);
        check_eq("count_after_abort", obs_re.size(), 8 * 2 * N_SF);

        @(negedge clk);
        start = 1'b1; N_cell_ID = 9'd77; two_ports = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("emit_before_reset", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("areset_valid", out_valid, 0);
        check_eq("areset_busy", busy, 0);
        check_eq("areset_re", re_addr, 0);
        check_eq("areset_sym", sym_idx, 0);
        check_eq("areset_vshift", v_shift, 0);
        @(negedge clk);
        check_eq("areset_no_done", done, 0);
        rst_n = 1'b1; out_ready = 1'b0;
        run(77, 1'b0, 0, -1, 1'b1);
        check_eq("count_after_reset", obs_re.size(), 8 * 1 * N_SF);
        repeat (3) @(negedge clk);
        check_eq("no_queued_start", busy, 0);

        for (int id = 0; id <= 503; id++) run(id, id[0], 0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nrs_re_sequencer.md
# nrs_re_sequencer

Parametrised NRS resource-element sequencer for the NB-IoT receive path, sitting between cell search (which supplies N_cell_ID) and the resource demapper / channel estimator. Each start pulse registers the cell ID, derives v_shift = N_cell_ID mod 6 in one cycle, then streams every NRS position of N_SF subframes over a valid/ready handshake. Each position carries subcarrier, OFDM symbol, antenna port and flat RE address. Supports one or two NRS antenna ports (2000/2001), selected at run time.

## Interface
- MAX_PORTS, 2: max NRS ports supported, 1 or 2; with 1, two_ports is ignored.
- N_SF, 1: subframes emitted per start, 1..16.
- SF_W, max(1,clog2(N_SF)): width of sf_idx.

- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- N_cell_ID  in  9  physical cell ID 0..503, sampled on accepted start.
- two_ports  in  1  sampled on accepted start; 1 = emit ports 0 and 1.
- abort  in  1  synchronous; returns to IDLE next edge, no done.
- out_ready  in  1  consumer ready.
- out_valid  out  1  position valid.
- index_demap  out  4  subcarrier k, 0..11.
- sym_idx  out  4  OFDM symbol in subframe: 5, 6, 12 or 13.
- port_idx  out  1  0 = port 2000, 1 = port 2001.
- sf_idx  out  SF_W  subframe counter within the run.
- re_addr  out  8  sym_idx*12 + index_demap, 60..167.
- v_shift  out  3  registered N_cell_ID mod 6.
- busy  out  1  high in LOAD and EMIT.
- done  out  1  one-cycle pulse after the last accepted position.

## Operation
- States: IDLE, LOAD, EMIT, DONE.
- IDLE -> LOAD on start. N_cell_ID and two_ports are latched.
- LOAD (1 cycle): v_shift is registered from x = n0 + 2(n1+n3+n5+n7) + 4(n2+n4+n6+n8). x is 5 bits, max 23. Reduce with subtract-6 stages. All counters clear.
- LOAD -> EMIT.
- EMIT: loop nesting, outer to inner: sf (0..N_SF-1), slot (0..1), sym (5,6 offset by 7*slot), port (0..P-1), m (0..1).
  - P = 2 when MAX_PORTS==2 and two_ports latched high, else 1.
  - k = 6m + ((v + v_shift) mod 6).
  - v = 3*((sym is second of slot) XOR port).
  - Width rule: the v + v_shift sum is 4 bits; reduce with a single conditional subtract of 6.
- Counters advance only on out_valid && out_ready.
- The last transfer is sf=N_SF-1, slot1, sym13, port P-1, m1. On it: EMIT -> DONE.
- DONE (1 cycle): done=1, out_valid=0. DONE -> IDLE.
- Positions per run: 8*P*N_SF.
- start while busy or in DONE is ignored, with no queuing.
- abort has priority over start and over the handshake in any state: next state is IDLE and out_valid drops.
- A start coincident with abort in IDLE is ignored.
- Outputs other than out_valid, busy and done hold their last value in IDLE.

## Timing
- Reset values: all outputs 0. State = IDLE, counters 0. sym_idx resets to 0, not 5.
- Latency: start sampled at edge E0, LOAD during the next cycle, out_valid high after E1. The first position is visible one cycle after LOAD.
- Throughput: one position per cycle while out_ready is held high. With P=1, a run takes 2 + 8*N_SF cycles to done.
- Handshake: while out_valid && !out_ready, all payload outputs are held stable. out_valid never drops without a transfer except on abort or reset.
- done asserts the cycle after the last transfer edge. busy is low in that same cycle.
- Async reset mid-run: immediate IDLE with outputs 0, and no done.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package nrs_pkg holds:
  - state enum.
  - NRS_SYM0=5, NRS_SYM1=6, SYM_PER_SLOT=7, N_SC=12.
  - MAX_CELL_ID=503.
- Sub-module nrs_vshift_mod6: combinational, 9-bit cell ID in, 3-bit mod 6 out. It is instantiated once and also reused by the TX generator.
- The top contains the FSM, the nested counters and the k/re_addr datapath registers.

## Test plan
- N_cell_ID=0, two_ports=0, N_SF=1, out_ready=1 -> v_shift=0. re_addr sequence is 60,66,75,81,144,150,159,165, then done exactly one cycle later.
- N_cell_ID=503, two_ports=1 -> v_shift=5. k sequence for slot0 is 5,11 (p0, sym5), 2,8 (p1, sym5), 2,8 (p0, sym6), 5,11 (p1, sym6). 16 transfers in total.
- Sweep N_cell_ID over 0..503 -> v_shift equals ID mod 6, and every k lies in 0..11.
- Random out_ready backpressure (30% low) -> payload stable while stalled, no position lost or duplicated, transfer count 8*P*N_SF.
- N_SF=4: start, abort asserted at the 10th transfer -> IDLE next cycle, no done. A following start restarts at sf_idx=0, sym_idx=5.
- rst_n asserted while in EMIT, then a start pulse during LOAD -> outputs 0 immediately. The second start is ignored, so the run count is unchanged.
